// File: rtl/mips_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave).
interface mips_fetch_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rdata
   );
endinterface

// File: rtl/mips_fetch_stage.sv
// MIPS instruction fetch stage: PC, IF/ID register, one-entry stall buffer.
// Optional performance counters enabled by defining FETCH_PERF_CNT_EN.
//
// state   | meaning
// FETCH   | request outstanding at pc_current; accept word when imem_ready
// HOLD    | word parked in hold buffer while decode stalls; no request
// DISCARD | redirected with a request in flight; wait for it and drop it
module mips_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall_id,
   input  logic                  redirect,
   input  logic [31:0]           branch_target,
   mips_fetch_stage_if.master    imem,
   output logic [31:0]           pc_current,
   output logic [31:0]           instr_if,
   output logic [31:0]           instr_id,
   output logic [31:0]           pc_plus4_id,
   output logic                  valid_id,
   output logic [31:0]           fetch_count,
   output logic [31:0]           stall_count
);

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      HOLD    = 2'd1,
      DISCARD = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] hold_instr, hold_pc4;
   logic [31:0] discard_addr;
   logic [31:0] pc_plus4;
   logic        accept;
   logic        load_fetch, load_hold;

   assign pc_plus4 = pc_current + 32'd4;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= FETCH;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FETCH: begin
            if (redirect)                    state_nxt = imem.imem_ready ? FETCH : DISCARD;
            else if (imem.imem_ready && stall_id) state_nxt = HOLD;
         end
         HOLD:    if (redirect || !stall_id) state_nxt = FETCH;
         DISCARD: if (imem.imem_ready)       state_nxt = FETCH;
         default: state_nxt = FETCH;
      endcase
   end

   always_comb begin
      imem.imem_req  = !reset && (state != HOLD);
      imem.imem_addr = (state == DISCARD) ? discard_addr : pc_current;
      accept         = (state == FETCH) && imem.imem_ready && !redirect;
      load_fetch     = accept && !stall_id;
      load_hold      = (state == HOLD) && !redirect && !stall_id;
      instr_if       = accept ? imem.imem_rdata : 32'h0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_current   <= RESET_PC;
         instr_id     <= 32'h0;
         pc_plus4_id  <= 32'h0;
         valid_id     <= 1'b0;
         hold_instr   <= 32'h0;
         hold_pc4     <= 32'h0;
         discard_addr <= RESET_PC;
      end else begin
         if (redirect)
            pc_current <= branch_target & ~32'h3;
         else if (accept)
            pc_current <= pc_plus4;

         // the in-flight address must stay on the bus until memory answers
         if (redirect && (state == FETCH) && !imem.imem_ready)
            discard_addr <= pc_current;

         if (accept && stall_id) begin
            hold_instr <= imem.imem_rdata;
            hold_pc4   <= pc_plus4;
         end

         if (redirect) begin
            valid_id <= 1'b0;
            instr_id <= 32'h0;
         end else if (load_fetch) begin
            instr_id    <= imem.imem_rdata;
            pc_plus4_id <= pc_plus4;
            valid_id    <= 1'b1;
         end else if (load_hold) begin
            instr_id    <= hold_instr;
            pc_plus4_id <= hold_pc4;
            valid_id    <= 1'b1;
         end else if (!stall_id) begin
            valid_id <= 1'b0;
            instr_id <= 32'h0;
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_count <= 32'h0;
         stall_count <= 32'h0;
      end else begin
         if (load_fetch || load_hold) fetch_count <= fetch_count + 32'd1;
         if (stall_id)                stall_count <= stall_count + 32'd1;
      end
   end
`else
   assign fetch_count = 32'h0;
   assign stall_count = 32'h0;
`endif

endmodule

// File: doc/mips_fetch_stage.md
MIPS_FETCH_STAGE -- requirements
Module: mips_fetch_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] shall be 0).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 stall_id  input  1  decode stalled (hazard); IF/ID shall hold.
REQ-005 redirect  input  1  branch/jump taken; flush fetch and restart at branch_target.
REQ-006 branch_target  input  32  redirect address; bits [1:0] ignored (forced 00).
REQ-007 imem_req  output  1  instruction memory request.
REQ-008 imem_addr  output  32  request address; stable while imem_req=1 and imem_ready=0.
REQ-009 imem_ready  input  1  read complete; imem_rdata valid this cycle.
REQ-010 imem_rdata  input  32  instruction word.
REQ-011 pc_current  output  32  PC register (next/current fetch address).
REQ-012 instr_if  output  32  imem_rdata when accepted in FETCH, else 32'h0.
REQ-013 instr_id, pc_plus4_id  output  32 each  IF/ID pipeline register.
REQ-014 valid_id  output  1  IF/ID holds a real instruction (0 = bubble, instr_id=0 NOP).
REQ-015 fetch_count, stall_count  output  32 each  performance counters (see Configuration).

Function
REQ-016 FSM states SHALL be FETCH, HOLD, DISCARD; reset state FETCH.
REQ-017 FETCH: imem_req=1, imem_addr=pc_current.
REQ-018 FETCH, imem_ready=1, stall_id=0, redirect=0: instr_id<=imem_rdata, pc_plus4_id<=pc_current+4, valid_id<=1, pc_current<=pc_current+4; stay FETCH (back-to-back, 1 instr/cycle with zero-wait memory).
REQ-019 FETCH, imem_ready=0, stall_id=0, redirect=0: valid_id<=0, instr_id<=0 (bubble); PC holds.
REQ-020 FETCH, imem_ready=1, stall_id=1: word captured in one-entry hold buffer, pc_current<=pc_current+4, go HOLD; IF/ID unchanged.
REQ-021 stall_id=1 (any state, no redirect): instr_id, pc_plus4_id, valid_id unchanged.
REQ-022 HOLD: imem_req=0; when stall_id=0, buffer moves to IF/ID (valid_id<=1), go FETCH.
REQ-023 redirect SHALL have priority over stall_id and imem_ready: valid_id<=0, instr_id<=0, pc_current<=branch_target&~3, hold buffer dropped.
REQ-024 redirect in FETCH with imem_ready=0: go DISCARD; imem_req stays 1 and imem_addr holds the old address until imem_ready; returned word dropped, then FETCH at new PC.
REQ-025 redirect in FETCH with imem_ready=1, or in HOLD: word dropped, next state FETCH at target.
REQ-026 redirect in DISCARD: pc_current<=new target; remain DISCARD until imem_ready.
REQ-027 PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-028 Each instruction word SHALL enter IF/ID exactly once, in address order between redirects; no word lost or duplicated under stall.

Reset
REQ-029 While reset=1 (asynchronous): pc_current=RESET_PC, instr_id=0, pc_plus4_id=0, valid_id=0, state FETCH, counters 0, imem_req=0.
REQ-030 First cycle after reset release: imem_req=1, imem_addr=RESET_PC.
REQ-031 Reset mid-request or in DISCARD/HOLD: pending word abandoned; no partial IF/ID update.

Configuration
REQ-032 Macro FETCH_PERF_CNT_EN: defined -> fetch_count increments on each IF/ID load with valid_id<=1; stall_count increments each cycle stall_id=1; both wrap at 2^32.
REQ-033 Macro undefined -> ports exist, tied to 32'h0; no counter registers; all other behaviour identical.

Verification
REQ-034 RESET_PC=0, zero-wait memory, no stall, 4 cycles -> imem_addr 0,4,8,C; valid_id=1 from cycle 2; pc_plus4_id 4,8,C.
REQ-035 imem_ready low 2 cycles at addr 8 -> two bubbles (valid_id=0, instr_id=0); pc_current=8 held; word@8 then loaded once.
REQ-036 stall_id=1 for 3 cycles while word@C returns -> HOLD, imem_req=0, IF/ID holds word@8; on release word@C enters IF/ID, next fetch 0x10.
REQ-037 redirect to 0x43 during outstanding request at 0x20 (imem_ready=0) -> DISCARD, imem_addr=0x20 until ready, data dropped, next fetch 0x40.
REQ-038 redirect and stall_id both high in HOLD -> valid_id=0, buffer dropped, fetch at target; pc_current=0xFFFFFFFC fetched -> next 0x0.
REQ-039 With FETCH_PERF_CNT_EN: after REQ-036 sequence stall_count=3; without it both counters read 0.
